// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: debounced keypad front end and tic-tac-toe game FSM with win/draw detection
module ttt_game_ctrl #(
   parameter int DB_CYCLES = 50000,
   parameter int DB_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] key_data,
   output logic [2:0]  state,
   output logic        is_main,
   output logic [17:0] board,
   output logic        turn_o,
   output logic [1:0]  winner,
   output logic [8:0]  win_line,
   output logic        move_err
);
   typedef enum logic [2:0] {S_MAIN = 3'd0, S_PLAY = 3'd1, S_CHECK = 3'd2, S_WIN = 3'd3, S_DRAW = 3'd4} state_t;
   localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);
   // rows, columns, diagonals as cell masks
   localparam logic [71:0] LINES = {9'h007, 9'h038, 9'h1c0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};

   logic [11:0]     sync_q, ks_q, cand_q, stable_q, prev_q;
   logic [DB_W-1:0] cnt_q;
   state_t          state_q;
   logic            is_main_q, turn_q, move_err_q;
   logic [17:0]     board_q, board_wr;
   logic [1:0]      winner_q, mark;
   logic [8:0]      win_line_q, occ, mine, line_hit;
   logic [3:0]      moves_q;
   logic            key_evt, start, to_main, place, occ_hit;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sync_q   <= '0;
         ks_q     <= '0;
         cand_q   <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
      end else begin
         sync_q <= key_data;
         ks_q   <= sync_q;
         prev_q <= stable_q;
         if (ks_q != cand_q) begin
            cand_q <= ks_q;
            cnt_q  <= '0;
         end else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + DB_W'(1);
         if (cnt_q == CNT_MAX) stable_q <= cand_q;
      end

   // only a release-then-single-key transition counts as a press
   assign key_evt = (prev_q == '0) && $onehot(stable_q);

   always_comb begin
      mark     = turn_q ? 2'b10 : 2'b01;
      occ      = '0;
      mine     = '0;
      line_hit = '0;
      board_wr = board_q;
      for (int i = 0; i < 9; i++) begin
         occ[i]            = |board_q[2*i+:2];
         mine[i]           = board_q[2*i+:2] == mark;
         board_wr[2*i+:2]  = stable_q[i] ? mark : board_q[2*i+:2];
      end
      for (int j = 0; j < 8; j++)
         line_hit = ((mine & LINES[9*j+:9]) == LINES[9*j+:9]) ? (line_hit | LINES[9*j+:9]) : line_hit;
   end

   assign occ_hit = |(stable_q[8:0] & occ);
   assign start   = key_evt && ((state_q == S_MAIN && stable_q[0]) ||
                    ((state_q == S_WIN || state_q == S_DRAW) && stable_q[11]));
   assign to_main = key_evt && stable_q[9] && (state_q == S_PLAY || state_q == S_WIN || state_q == S_DRAW);
   assign place   = key_evt && state_q == S_PLAY && |stable_q[8:0] && !occ_hit;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q    <= S_MAIN;
         is_main_q  <= 1'b1;
         board_q    <= '0;
         turn_q     <= 1'b0;
         winner_q   <= 2'b00;
         win_line_q <= '0;
         move_err_q <= 1'b0;
         moves_q    <= '0;
      end else begin
         move_err_q <= key_evt && state_q == S_PLAY && occ_hit;
         if (start) begin
            state_q    <= S_PLAY;
            is_main_q  <= 1'b0;
            board_q    <= '0;
            moves_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_line_q <= '0;
         end else if (to_main) begin
            state_q    <= S_MAIN;
            is_main_q  <= 1'b1;
            win_line_q <= '0;
         end else
            case (state_q)
               S_PLAY:
                  if (place) begin
                     board_q <= board_wr;
                     moves_q <= moves_q + 4'd1;
                     state_q <= S_CHECK;
                  end
               S_CHECK:
                  if (|line_hit) begin
                     state_q    <= S_WIN;
                     winner_q   <= mark;
                     win_line_q <= line_hit;
                  end else if (moves_q == 4'd9) begin
                     state_q  <= S_DRAW;
                     winner_q <= 2'b11;
                  end else begin
                     turn_q  <= ~turn_q;
                     state_q <= S_PLAY;
                  end
               default: ;
            endcase
      end

   assign state    = state_q;
   assign is_main  = is_main_q;
   assign board    = board_q;
   assign turn_o   = turn_q;
   assign winner   = winner_q;
   assign win_line = win_line_q;
   assign move_err = move_err_q;
endmodule
